// File: rtl/rr_handshake_arbiter_pkg.sv
// Shared definitions for the round-robin handshake arbiter: FSM state
// encoding and default sizing.
package rr_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_ACK = 3'd2,
    DONE     = 3'd3,
    ERR      = 3'd4
  } arb_state_e;

  localparam int DEF_N       = 4;
  localparam int DEF_TIMEOUT = 8;

endpackage

// File: rtl/rr_handshake_arbiter_if.sv
// Requester/resource bundle between the requesters, the arbiter and the
// shared engine.
interface rr_handshake_arbiter_if #(
  parameter int N = rr_arb_pkg::DEF_N
) ();

  // Handshake: a requester holds req[i] high until it sees cmp[i] or err
  // while gnt[i] is high; gnt is held for the whole transaction. The engine
  // sees a one-cycle res_start and answers with a one-cycle res_ack no
  // earlier than the cycle after res_start.
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         res_start;
  logic         res_ack;
  logic [N-1:0] cmp;
  logic         err;
  logic         busy;

  modport slave (
    input  req,
    input  res_ack,
    output gnt,
    output res_start,
    output cmp,
    output err,
    output busy
  );

  modport master (
    output req,
    output res_ack,
    input  gnt,
    input  res_start,
    input  cmp,
    input  err,
    input  busy
  );

endinterface

// File: rtl/rr_handshake_arbiter_pick.sv
// Combinational round-robin picker: the first set request at or after ptr
// (wrapping) wins; returns it one-hot and as an index.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [PW-1:0] win_idx
);

  logic          found;
  logic [PW-1:0] cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = PW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found         = 1'b1;
        win_oh[cand]  = 1'b1;
        win_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter sequencing start -> ack -> complete for the granted
// requester, with a timeout abort while waiting for ack.
module rr_handshake_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  rr_handshake_arbiter_if.slave        bus,
  output arb_state_e                   state_dbg
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(N);

  arb_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  cmp_q, cmp_d;
  logic          err_q, err_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;

  logic [N-1:0]  pick_oh;
  logic [PW-1:0] pick_idx;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    cmp_d   = '0;
    err_d   = 1'b0;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = START;
          gnt_d   = pick_oh;
          idx_d   = pick_idx;
          start_d = 1'b1;
        end
      end
      START: begin
        // Ack this early cannot belong to the start just issued.
        state_d = WAIT_ACK;
        timer_d = '0;
      end
      WAIT_ACK: begin
        if (bus.res_ack) begin
          state_d = DONE;
          cmp_d   = gnt_q;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DONE, ERR: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = (idx_q == PW'(N - 1)) ? '0 : idx_q + PW'(1);
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      cmp_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      cmp_q   <= cmp_d;
      err_q   <= err_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.cmp       = cmp_q;
  assign bus.err       = err_q;
  assign bus.res_start = start_q;
  assign bus.busy      = busy_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Directed bench for rr_handshake_arbiter: drivers push expected start/cmp/err
// events with their cycle stamps, a negedge monitor pops and compares them.
module tb_rr_handshake_arbiter;
  import rr_arb_pkg::*;

  localparam int N       = 4;
  localparam int TIMEOUT = 8;
  localparam int W       = 2 + N + 16;

  localparam logic [1:0] EV_START = 2'd1;
  localparam logic [1:0] EV_CMP   = 2'd2;
  localparam logic [1:0] EV_ERR   = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  arb_state_e state_dbg;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic       prev_start = 1'b0;
  logic [W-1:0] exp_q[$];

  rr_handshake_arbiter_if #(.N(N)) bus ();

  rr_handshake_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input logic [1:0] t, input logic [N-1:0] v, input int c);
    exp_q.push_back({t, v, 16'(c)});
  endfunction

  // scoreboard monitor
  task automatic ev_check(input logic [1:0] t, input logic [N-1:0] v, input string name);
    logic [W-1:0] act;
    logic [W-1:0] exp;
    act = {t, v, 16'(cyc)};
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_%s actual=%0h expected=none (cycle %0d)", name, act, cyc);
    end else begin
      exp = exp_q.pop_front();
      check({"event_", name}, 32'(act), 32'(exp));
    end
  endtask

  always @(negedge clk) begin
    if (bus.res_start) begin
      ev_check(EV_START, bus.gnt, "start");
      check("busy_at_start", 32'(bus.busy), 32'd1);
    end
    if (|bus.cmp) begin
      ev_check(EV_CMP, bus.cmp, "cmp");
      check("gnt_during_cmp", 32'(bus.gnt), 32'(bus.cmp));
    end
    if (bus.err) ev_check(EV_ERR, bus.gnt, "err");
    check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    check("cmp_err_excl", 32'((|bus.cmp) && bus.err), 32'd0);
    check("start_single", 32'(bus.res_start && prev_start), 32'd0);
    prev_start = bus.res_start;
  end

  // driver: one transaction; ack_at = edges after the start edge, -1 = none
  task automatic run_txn(input logic [N-1:0] r, input logic [N-1:0] g,
                         input int ack_at, input bit keep);
    int c;
    int fin;
    c = cyc;
    push_ev(EV_START, g, c + 1);
    if (ack_at >= 2 && ack_at <= TIMEOUT + 1) begin
      fin = c + 1 + ack_at;
      push_ev(EV_CMP, g, fin);
    end else begin
      fin = c + 2 + TIMEOUT;
      push_ev(EV_ERR, g, fin);
    end
    bus.req = r;
    while (cyc < fin + 1) begin
      @(negedge clk);
      if (!keep && cyc == c + 1) bus.req = '0;
      bus.res_ack = (ack_at >= 0) && (cyc == c + ack_at);
    end
    bus.res_ack = 1'b0;
    check("gnt_released", 32'(bus.gnt), 32'd0);
    check("busy_released", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},   32'(bus.gnt),       32'd0);
    check({tag, "_cmp"},   32'(bus.cmp),       32'd0);
    check({tag, "_err"},   32'(bus.err),       32'd0);
    check({tag, "_start"}, 32'(bus.res_start), 32'd0);
    check({tag, "_busy"},  32'(bus.busy),      32'd0);
    check({tag, "_state"}, 32'(state_dbg),     32'(IDLE));
  endtask

  initial begin
    int c;
    bus.req     = '0;
    bus.res_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // single request, ack two edges after start
    run_txn(4'b0100, 4'b0100, 2, 1'b0);

    // reset during WAIT_ACK: pointer is 3 here, so req 1 wins
    c = cyc;
    push_ev(EV_START, 4'b0010, c + 1);
    bus.req = 4'b0010;
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    check("wait_ack_reached", 32'(state_dbg), 32'(WAIT_ACK));
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    rst = 1'b0;
    bus.res_ack = 1'b1;
    @(negedge clk);
    bus.res_ack = 1'b0;
    check("idle_ack_ignored", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);

    // round robin with all requests held, pointer restarted at 0
    run_txn(4'b1111, 4'b0001, 2, 1'b1);
    run_txn(4'b1111, 4'b0010, 2, 1'b1);
    run_txn(4'b1111, 4'b0100, 2, 1'b1);
    run_txn(4'b1111, 4'b1000, 2, 1'b1);
    run_txn(4'b1111, 4'b0001, 2, 1'b0);

    // timeout on req 1, then pointer moves to 2
    run_txn(4'b0010, 4'b0010, -1, 1'b0);
    run_txn(4'b0111, 4'b0100, 2, 1'b0);

    // ack in START only -> timeout; ack on timeout edge -> completion
    run_txn(4'b0001, 4'b0001, 1, 1'b0);
    run_txn(4'b0100, 4'b0100, TIMEOUT + 1, 1'b0);

    // ack arriving while in ERR is ignored
    run_txn(4'b0001, 4'b0001, TIMEOUT + 2, 1'b0);

    // requester 3 withdraws right after grant
    run_txn(4'b1000, 4'b1000, 3, 1'b0);

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check_idle_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
